// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, default widths and sizing helpers.
package dmem_ctrl_pkg;

  localparam int DEF_ADDR_W      = 7;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_MAX_CPU_RUN = 4;
  localparam int WORDS           = 2 ** (DEF_ADDR_W - 2);

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_ARB     = 2'd1,
    ST_DBG_ACK = 2'd2
  } state_t;

  function automatic int words_for(input int addr_w);
    return 2 ** (addr_w - 2);
  endfunction

  // Starvation counter must be able to hold MAX_CPU_RUN itself.
  function automatic int run_cnt_w(input int max_run);
    return $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/dmem_init_walker.sv
// Steps a word index across the whole memory once after reset so the arbiter can clear it.
// Instantiated only when DMEM_INIT_CLEAR_EN is defined.
module dmem_init_walker
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-3:0] idx,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-3:0] LAST_IDX = (ADDR_W - 2)'(words_for(ADDR_W) - 1);

  assign done = busy && (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      idx <= idx + 1'b1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (priority) and a debug/loader port.
// Define DMEM_INIT_CLEAR_EN to clear every memory word after reset before arbitration starts.
module dmem_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int MAX_CPU_RUN = DEF_MAX_CPU_RUN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  output logic              init_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W   = run_cnt_w(MAX_CPU_RUN);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CPU_RUN);

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  starve_cnt;
  logic              gnt_cpu;
  logic              gnt_dbg;
  logic              init_wr;
  logic              init_done;
  logic [ADDR_W-3:0] init_idx;

`ifdef DMEM_INIT_CLEAR_EN
  localparam state_t RESET_STATE = ST_INIT;
  logic walker_busy;

  dmem_init_walker #(
    .ADDR_W(ADDR_W)
  ) u_walker (
    .clk  (clk),
    .rst_n(rst_n),
    .idx  (init_idx),
    .busy (walker_busy),
    .done (init_done)
  );

  assign init_busy = walker_busy;
  assign init_wr   = rst_n && (state == ST_INIT);
`else
  localparam state_t RESET_STATE = ST_ARB;

  assign init_idx  = '0;
  assign init_done = 1'b0;
  assign init_busy = 1'b0;
  assign init_wr   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET_STATE;
    end else begin
      state <= next_state;
    end
  end

  // Grants are suppressed while reset is held so the memory sees no access.
  always_comb begin
    next_state = state;
    gnt_dbg    = 1'b0;
    gnt_cpu    = 1'b0;
    if (rst_n) begin
      case (state)
        ST_INIT: begin
          if (init_done) begin
            next_state = ST_ARB;
          end
        end
        ST_ARB: begin
          gnt_dbg = dbg_req && (!cpu_req || starve_cnt == MAX_CNT);
          gnt_cpu = cpu_req && !gnt_dbg;
          if (gnt_dbg) begin
            next_state = ST_DBG_ACK;
          end
        end
        ST_DBG_ACK: begin
          gnt_cpu    = cpu_req;
          next_state = ST_ARB;
        end
        default: begin
          next_state = ST_ARB;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (init_wr) begin
      mem_addr  = {init_idx, 2'b00};
      mem_write = 1'b1;
    end else if (gnt_dbg) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
      mem_write = dbg_we;
      mem_read  = !dbg_we;
    end else if (gnt_cpu) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_write = cpu_we;
      mem_read  = !cpu_we;
    end
  end

  assign cpu_stall = cpu_req && !gnt_cpu;
  assign cpu_rdata = mem_rdata;
  assign dbg_ack   = (state == ST_DBG_ACK);

  // Counts CPU wins while DBG waits; any DBG grant or dropped request restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (state == ST_INIT || gnt_dbg || !dbg_req) begin
      starve_cnt <= '0;
    end else if (state == ST_ARB && gnt_cpu && starve_cnt != MAX_CNT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_rdata <= '0;
    end else if (gnt_dbg && !dbg_we) begin
      dbg_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter using a behavioural 32-word memory and an expected-data queue.
// Define DMEM_INIT_CLEAR_EN for both bench and RTL to also exercise the post-reset memory clear.
module tb_dmem_arbiter;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 32;

`ifdef DMEM_INIT_CLEAR_EN
  localparam logic EXP_INIT_BUSY_RST = 1'b1;
`else
  localparam logic EXP_INIT_BUSY_RST = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cpu_req, cpu_we, dbg_req, dbg_we;
  logic [ADDR_W-1:0] cpu_addr, dbg_addr;
  logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
  logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
  logic              cpu_stall, dbg_ack, init_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_read, mem_write;

  logic [DATA_W-1:0] mem [32];
  int                wr_count = 0;
  logic              poke_en = 1'b0;
  logic [4:0]        poke_idx = '0;
  logic [DATA_W-1:0] poke_val = '0;

  int                n_checks = 0;
  int                n_fail = 0;
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_val;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req  (dbg_req),
    .dbg_we   (dbg_we),
    .dbg_addr (dbg_addr),
    .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata),
    .dbg_ack  (dbg_ack),
    .init_busy(init_busy),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  // Single-port memory: combinational read, write committed at the rising edge.
  assign mem_rdata = mem[mem_addr[ADDR_W-1:2]];

  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_idx] <= poke_val;
    end else if (mem_write) begin
      mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
`ifdef DMEM_INIT_CLEAR_EN
    for (int i = 0; i < 40 && init_busy; i++) step();
    n_checks++;
    if (init_busy !== 1'b0) begin
      n_fail++; $display("[TB] FAIL init_timeout: init_busy got %b expected 0", init_busy);
    end
`endif
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h18; cpu_wdata = 32'h1234_5678;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h10; dbg_wdata = 32'hCAFE_F00D;
    for (int i = 0; i < 32; i++) begin
      poke_en = 1'b1; poke_idx = i[4:0]; poke_val = '0;
      step();
    end
    poke_en = 1'b0;
    #4;
    n_checks += 7;
    if (mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_write: got %b expected 0", mem_write); end
    if (mem_read !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_mem_read: got %b expected 0", mem_read); end
    if (mem_addr !== 7'h00) begin n_fail++; $display("[TB] FAIL rst_mem_addr: got %h expected 00", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", mem_wdata); end
    if (cpu_stall !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_cpu_stall: got %b expected 1", cpu_stall); end
    if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL rst_dbg: ack %b rdata %h expected 0 / 0", dbg_ack, dbg_rdata);
    end
    if (init_busy !== EXP_INIT_BUSY_RST) begin
      n_fail++; $display("[TB] FAIL rst_init_busy: got %b expected %b", init_busy, EXP_INIT_BUSY_RST);
    end
    drive_idle();
    step();
    release_reset();
    step();
  endtask

  task automatic test_cpu_only();
    int wr0;
    logic [ADDR_W-1:0] load_addr [2];
    load_addr[0] = 7'h18;
    load_addr[1] = 7'h1B;
    wr0 = wr_count;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h18; cpu_wdata = 32'h0000_0021;
    #4;
    n_checks += 2;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 7'h18 || mem_wdata !== 32'h21) begin
      n_fail++; $display("[TB] FAIL cpu_store_drive: we %b re %b addr %h data %h expected 1 0 18 00000021",
                         mem_write, mem_read, mem_addr, mem_wdata);
    end
    if (cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_store_stall: got %b expected 0", cpu_stall); end
    step();
    for (int i = 0; i < 2; i++) begin
      cpu_we = 1'b0; cpu_addr = load_addr[i];
      exp_q.push_back(32'h0000_0021);
      #4;
      n_checks += 3;
      if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== load_addr[i]) begin
        n_fail++; $display("[TB] FAIL cpu_load_drive: re %b we %b addr %h expected 1 0 %h",
                           mem_read, mem_write, mem_addr, load_addr[i]);
      end
      if (cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL cpu_load_stall: got %b expected 0", cpu_stall); end
      exp_val = exp_q.pop_front();
      if (cpu_rdata !== exp_val) begin
        n_fail++; $display("[TB] FAIL cpu_load_data: got %h expected %h", cpu_rdata, exp_val);
      end
      step();
    end
    drive_idle();
    #4;
    n_checks += 2;
    if (wr_count !== wr0 + 1) begin n_fail++; $display("[TB] FAIL cpu_write_count: got %0d expected %0d", wr_count, wr0 + 1); end
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 7'h00) begin
      n_fail++; $display("[TB] FAIL idle_drive: re %b we %b addr %h expected 0 0 00", mem_read, mem_write, mem_addr);
    end
    step();
  endtask

  task automatic test_dbg_only();
    int wr0;
    wr0 = wr_count;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h10; dbg_wdata = 32'hDEAD_BEEF;
    #4;
    n_checks += 2;
    if (mem_write !== 1'b1 || mem_addr !== 7'h10 || mem_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("[TB] FAIL dbg_write_drive: we %b addr %h data %h expected 1 10 deadbeef",
                         mem_write, mem_addr, mem_wdata);
    end
    if (dbg_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL dbg_ack_early: got %b expected 0", dbg_ack); end
    step();
    #4;
    n_checks += 3;
    if (dbg_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL dbg_write_ack: got %b expected 1", dbg_ack); end
    if (mem_write !== 1'b0) begin n_fail++; $display("[TB] FAIL dbg_double_write: mem_write got %b expected 0", mem_write); end
    if (dbg_rdata !== 32'h0) begin n_fail++; $display("[TB] FAIL dbg_rdata_on_write: got %h expected 0", dbg_rdata); end
    step();
    dbg_we = 1'b0;
    exp_q.push_back(32'hDEAD_BEEF);
    #4;
    n_checks += 2;
    if (wr_count !== wr0 + 1) begin n_fail++; $display("[TB] FAIL dbg_write_count: got %0d expected %0d", wr_count, wr0 + 1); end
    if (mem_read !== 1'b1 || dbg_ack !== 1'b0) begin
      n_fail++; $display("[TB] FAIL dbg_read_grant: re %b ack %b expected 1 0", mem_read, dbg_ack);
    end
    step();
    dbg_req = 1'b0;
    #4;
    n_checks += 2;
    if (dbg_ack !== 1'b1) begin n_fail++; $display("[TB] FAIL dbg_read_ack: got %b expected 1", dbg_ack); end
    exp_val = exp_q.pop_front();
    if (dbg_rdata !== exp_val) begin n_fail++; $display("[TB] FAIL dbg_read_data: got %h expected %h", dbg_rdata, exp_val); end
    step();
    #4;
    n_checks++;
    if (dbg_ack !== 1'b0 || dbg_rdata !== exp_val) begin
      n_fail++; $display("[TB] FAIL dbg_hold: ack %b rdata %h expected 0 %h", dbg_ack, dbg_rdata, exp_val);
    end
    step();
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h10;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 7'h18;
    exp_q.push_back(32'h0000_0021);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) dbg_req = 1'b0;
      #4;
      n_checks += 3;
      if (cpu_stall !== (i == 4)) begin
        n_fail++; $display("[TB] FAIL starve_stall_c%0d: got %b expected %b", i, cpu_stall, (i == 4));
      end
      if (mem_addr !== ((i == 4) ? 7'h18 : 7'h10)) begin
        n_fail++; $display("[TB] FAIL starve_addr_c%0d: got %h expected %h", i, mem_addr, ((i == 4) ? 7'h18 : 7'h10));
      end
      if (dbg_ack !== (i == 5)) begin
        n_fail++; $display("[TB] FAIL starve_ack_c%0d: got %b expected %b", i, dbg_ack, (i == 5));
      end
      if (i == 5) begin
        n_checks++;
        exp_val = exp_q.pop_front();
        if (dbg_rdata !== exp_val) begin n_fail++; $display("[TB] FAIL starve_dbg_data: got %h expected %h", dbg_rdata, exp_val); end
      end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_simultaneous();
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    rd_addr[0] = 7'h08; rd_data[0] = 32'h66;
    rd_addr[1] = 7'h04; rd_data[1] = 32'h55;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 7'h04; cpu_wdata = 32'h55;
    dbg_we = 1'b1; dbg_addr = 7'h08; dbg_wdata = 32'h66;
    for (int i = 0; i < 9; i++) begin
      dbg_req = !(i == 2 || i == 8);
      #4;
      n_checks += 3;
      if (cpu_stall !== (i == 7)) begin
        n_fail++; $display("[TB] FAIL simul_stall_c%0d: got %b expected %b", i, cpu_stall, (i == 7));
      end
      if (mem_addr !== ((i == 7) ? 7'h08 : 7'h04)) begin
        n_fail++; $display("[TB] FAIL simul_addr_c%0d: got %h expected %h", i, mem_addr, ((i == 7) ? 7'h08 : 7'h04));
      end
      if (dbg_ack !== (i == 8)) begin
        n_fail++; $display("[TB] FAIL simul_ack_c%0d: got %b expected %b", i, dbg_ack, (i == 8));
      end
      step();
    end
    drive_idle();
    cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cpu_addr = rd_addr[i];
      exp_q.push_back(rd_data[i]);
      #4;
      n_checks++;
      exp_val = exp_q.pop_front();
      if (cpu_rdata !== exp_val) begin n_fail++; $display("[TB] FAIL simul_readback_%0d: got %h expected %h", i, cpu_rdata, exp_val); end
      step();
    end
    drive_idle();
    step();
  endtask

  task automatic test_reset_mid_dbg();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 7'h0C; dbg_wdata = 32'h77;
    #3;
    n_checks++;
    if (mem_write !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_grant: mem_write got %b expected 1", mem_write); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (mem_write !== 1'b0 || mem_addr !== 7'h00) begin
      n_fail++; $display("[TB] FAIL midrst_drive: we %b addr %h expected 0 00", mem_write, mem_addr);
    end
    dbg_req = 1'b0;
    step();
    step();
    release_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h0C;
    exp_q.push_back(32'h0);
    #4;
    n_checks += 3;
    if (dbg_ack !== 1'b0 || dbg_rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL midrst_dbg: ack %b rdata %h expected 0 0", dbg_ack, dbg_rdata);
    end
    if (cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_arb: cpu_stall got %b expected 0", cpu_stall); end
    exp_val = exp_q.pop_front();
    if (cpu_rdata !== exp_val) begin n_fail++; $display("[TB] FAIL midrst_abandoned: got %h expected %h", cpu_rdata, exp_val); end
    step();
    #4;
    n_checks++;
    if (dbg_ack !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_late_ack: got %b expected 0", dbg_ack); end
    drive_idle();
    step();
  endtask

`ifdef DMEM_INIT_CLEAR_EN
  task automatic test_init_clear();
    int busy_cycles;
    busy_cycles = 0;
    poke_en = 1'b1; poke_idx = 5'd6; poke_val = 32'd33;
    step();
    poke_en = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 7'h18;
    for (int i = 0; i < 40; i++) begin
      #4;
      if (!init_busy) break;
      busy_cycles++;
      n_checks++;
      if (cpu_stall !== 1'b1 || mem_write !== 1'b1 || mem_wdata !== 32'h0) begin
        n_fail++; $display("[TB] FAIL init_c%0d: stall %b we %b data %h expected 1 1 0", i, cpu_stall, mem_write, mem_wdata);
      end
      step();
    end
    exp_q.push_back(32'h0);
    n_checks += 3;
    if (busy_cycles !== 32) begin n_fail++; $display("[TB] FAIL init_length: got %0d expected 32", busy_cycles); end
    if (cpu_stall !== 1'b0) begin n_fail++; $display("[TB] FAIL init_after_stall: got %b expected 0", cpu_stall); end
    exp_val = exp_q.pop_front();
    if (cpu_rdata !== exp_val) begin n_fail++; $display("[TB] FAIL init_cleared: got %h expected %h", cpu_rdata, exp_val); end
    step();
    drive_idle();
    step();
  endtask
`endif

  initial begin
    drive_idle();
    $display("[TB] starting dmem_arbiter bench");
    test_reset();
    test_cpu_only();
    test_dbg_only();
    test_starvation();
    test_simultaneous();
    test_reset_mid_dbg();
`ifdef DMEM_INIT_CLEAR_EN
    test_init_clear();
`endif
    n_checks++;
    if (exp_q.size() !== 0) begin n_fail++; $display("[TB] FAIL scoreboard_drain: got %0d expected 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
